// File: rtl/beat_source_pkg.sv
// Shared types and constants for the beat_source producer and its throttle LFSR.
package beat_source_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } beat_state_e;

    // Pattern advance per beat: three lanes consume three consecutive values.
    localparam int unsigned LANE_STEP = 3;

    // x^8+x^6+x^5+x^4+1 as a right-shifting Galois feedback mask.
    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/beat_source_lfsr.sv
// 8-bit maximal-length Galois LFSR with enable; bit 0 gates beat presentation.
module beat_lfsr
    import beat_source_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic lsb
);

    logic [7:0] value;

    always_ff @(posedge clock) begin
        if (reset) begin
            value <= LFSR_SEED;
        end else if (enable) begin
            value <= {1'b0, value[7:1]} ^ (value[0] ? LFSR_TAPS : '0);
        end
    end

    assign lsb = value[0];

endmodule

// File: rtl/beat_source.sv
// Valid/ready beat producer emitting a three-lane incrementing pattern.
// Optional random throttling is enabled with `define BEAT_SOURCE_THROTTLE_EN.
module beat_source
    import beat_source_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_beats,
    input  logic [DATA_W-1:0] base,
    output logic              some_prefix_valid,
    input  logic              some_prefix_ready,
    output logic [DATA_W-1:0] some_prefix_bits_data_0,
    output logic [DATA_W-1:0] some_prefix_bits_data_1,
    output logic [DATA_W-1:0] some_prefix_bits_data_2,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  xfer_count
);

    localparam logic [DATA_W-1:0] STEP = DATA_W'(LANE_STEP);

    beat_state_e       state, state_nx;
    logic [DATA_W-1:0] ptr, ptr_nx;
    logic [CNT_W-1:0]  beats, beats_nx;
    logic              valid_nx, busy_nx, done_nx;
    logic [DATA_W-1:0] lane_0_nx, lane_1_nx, lane_2_nx;
    logic [CNT_W-1:0]  xfer_nx;
    logic              gate;
    logic              fire;

`ifdef BEAT_SOURCE_THROTTLE_EN
    beat_lfsr u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .enable (1'b1),
        .lsb    (gate)
    );
`else
    assign gate = 1'b1;
`endif

    assign fire = some_prefix_valid && some_prefix_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= IDLE;
            ptr                     <= '0;
            beats                   <= '0;
            some_prefix_valid       <= 1'b0;
            some_prefix_bits_data_0 <= '0;
            some_prefix_bits_data_1 <= '0;
            some_prefix_bits_data_2 <= '0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            xfer_count              <= '0;
        end else begin
            state                   <= state_nx;
            ptr                     <= ptr_nx;
            beats                   <= beats_nx;
            some_prefix_valid       <= valid_nx;
            some_prefix_bits_data_0 <= lane_0_nx;
            some_prefix_bits_data_1 <= lane_1_nx;
            some_prefix_bits_data_2 <= lane_2_nx;
            busy                    <= busy_nx;
            done                    <= done_nx;
            xfer_count              <= xfer_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        beats_nx  = beats;
        valid_nx  = some_prefix_valid;
        lane_0_nx = some_prefix_bits_data_0;
        lane_1_nx = some_prefix_bits_data_1;
        lane_2_nx = some_prefix_bits_data_2;
        busy_nx   = busy;
        done_nx   = 1'b0;
        xfer_nx   = xfer_count;

        case (state)
            IDLE: begin
                if (start) begin
                    xfer_nx  = '0;
                    beats_nx = num_beats;
                    if (num_beats == '0) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else begin
                        // Beat 0 goes out immediately; ptr already points at beat 1.
                        state_nx  = RUN;
                        busy_nx   = 1'b1;
                        valid_nx  = 1'b1;
                        lane_0_nx = base;
                        lane_1_nx = base + DATA_W'(1);
                        lane_2_nx = base + DATA_W'(2);
                        ptr_nx    = base + STEP;
                    end
                end
            end
            RUN: begin
                if (fire) begin
                    xfer_nx  = xfer_count + CNT_W'(1);
                    valid_nx = 1'b0;
                    if (xfer_nx == beats) begin
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end
                end
                if (state_nx == RUN && !valid_nx && gate) begin
                    valid_nx  = 1'b1;
                    lane_0_nx = ptr;
                    lane_1_nx = ptr + DATA_W'(1);
                    lane_2_nx = ptr + DATA_W'(2);
                    ptr_nx    = ptr + STEP;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
